// File: rtl/multicycle_subtractor_pkg.sv
// Shared definitions for the multi-cycle subtractor.
// - ALU_WIDTH / ALU_SLICE: default operand width and slice width. The adder
//   uses the same width.
// - state_e: FSM encoding (IDLE / CALC / DONE).
// - idx_bits(): width of the slice index counter. It is never zero wide.
package multicycle_subtractor_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_SLICE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width for n slices. This keeps a one-slice configuration legal.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_subtractor_slice.sv
// Combinational SLICE-bit subtractor with borrow.
// Ports:
//   a_s_i  - minuend slice
//   b_s_i  - subtrahend slice
//   bin_i  - borrow in
//   d_s_o  - (a_s - b_s - bin) mod 2^SLICE
//   bout_o - 1 iff a_s < b_s + bin (unsigned)
module multicycle_subtractor_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a_s_i,
    input  logic [SLICE-1:0] b_s_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] d_s_o,
    output logic             bout_o
);

    // The subtraction is one bit wider than the slice. When the true result is
    // negative, it wraps and sets the extra top bit, which is the borrow-out.
    logic [SLICE:0] wide;

    assign wide   = {1'b0, a_s_i} - {1'b0, b_s_i} - {{SLICE{1'b0}}, bin_i};
    assign d_s_o  = wide[SLICE-1:0];
    assign bout_o = wide[SLICE];

endmodule

// File: rtl/multicycle_subtractor.sv
// Multi-cycle subtractor: computes a - b - b_in at a rate of one SLICE-bit
// chunk per clock. A borrow is carried from each slice to the next.
// Ports:
//   clk, rst_n          - clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready - operand handshake. in_ready is high only in IDLE.
//   a, b, b_in          - minuend, subtrahend, borrow in
//   out_valid/out_ready - result handshake. The result is held until it is accepted.
//   diff                - (a - b - b_in) mod 2^WIDTH
//   b_out               - unsigned borrow out (a < b + b_in)
//   overflow            - signed overflow of the subtraction
//   zero                - diff == 0
module multicycle_subtractor
    import multicycle_subtractor_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SLICE = ALU_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow,
    output logic             zero
);

    localparam int              NSLICE   = WIDTH / SLICE;
    localparam int              IDXW     = idx_bits(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);
    localparam int              MSB      = WIDTH - 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              b_out_q, b_out_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // A single slice unit. The current slice of the operands is selected by idx.
    logic [SLICE-1:0]  a_s, b_s, d_s;
    logic              bout_s;
    logic [WIDTH-1:0]  diff_calc;

    assign a_s = a_q[idx_q*SLICE +: SLICE];
    assign b_s = b_q[idx_q*SLICE +: SLICE];

    multicycle_subtractor_slice #(.SLICE(SLICE)) u_slice (
        .a_s_i  (a_s),
        .b_s_i  (b_s),
        .bin_i  (borrow_q),
        .d_s_o  (d_s),
        .bout_o (bout_s)
    );

    // Result register with the current slice merged in. On the last CALC
    // edge the flags are taken from this value, so the top slice that is
    // being written on that same edge is included.
    always_comb begin
        diff_calc = diff_q;
        diff_calc[idx_q*SLICE +: SLICE] = d_s;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in;
                    idx_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                diff_d   = diff_calc;
                borrow_d = bout_s;
                idx_d    = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    b_out_d = bout_s;
                    ovf_d   = (a_q[MSB] != b_q[MSB]) && (diff_calc[MSB] != a_q[MSB]);
                    zero_d  = (diff_calc == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Directed vector bench for multicycle_subtractor (WIDTH=64, SLICE=16).
module tb_multicycle_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        b_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] diff;
    logic        b_out;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a transaction and wait for the result. On entry out_ready is held
    // at hold_ready. After the accept edge the operand ports are scrambled.
    // lat returns the number of edges from accept until out_valid is seen.
    // It returns -1 if the wait times out.
    task automatic issue(input vec_t v, input logic hold_ready, output int lat);
        @(negedge clk);
        a = v.a; b = v.b; b_in = v.bin; in_valid = 1'b1; out_ready = hold_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; b_in = ~v.bin;
        chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic check_result(input int idx, input vec_t v);
        string s;
        s = $sformatf("v%0d", idx);
        chk({s, "_diff"}, diff, v.diff);
        chk({s, "_bout"}, {63'd0, b_out}, {63'd0, v.bout});
        chk({s, "_ovf"},  {63'd0, overflow}, {63'd0, v.ovf});
        chk({s, "_zero"}, {63'd0, zero}, {63'd0, v.zero});
    endtask

    initial begin
        int lat;
        vecs[0] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{64'd7, 64'd3, 1'b1, 64'd3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst_diff", diff, 64'd0);
        chk("rst_flags", {61'd0, b_out, overflow, zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven vectors with full handshake and the latency check
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 5) continue; // exercised in the hand-written sequences below
            issue(vecs[i], 1'b1, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            check_result(i, vecs[i]);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ovalid_drop", i), {63'd0, out_valid}, 64'd0);
            chk($sformatf("v%0d_iready_back", i), {63'd0, in_ready}, 64'd1);
        end

        // Cross-slice borrow under backpressure. New operands are offered
        // while the result is held.
        issue(vecs[4], 1'b0, lat);
        chk("bp_latency", 64'(lat), 64'd4);
        @(negedge clk);
        a = 64'd99; b = 64'd1; b_in = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_ovalid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp%0d_iready", k), {63'd0, in_ready}, 64'd0);
            chk($sformatf("bp%0d_diff", k), diff, vecs[4].diff);
        end
        check_result(4, vecs[4]);
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_ovalid_drop", {63'd0, out_valid}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_no_new_op%0d", k), {62'd0, out_valid, in_ready}, 64'd1);
        end

        // Reset after two CALC edges aborts the operation.
        @(negedge clk);
        a = 64'd100; b = 64'd1; b_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ovalid", {63'd0, out_valid}, 64'd0);
        chk("abort_iready", {63'd0, in_ready}, 64'd1);
        chk("abort_diff", diff, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_idle%0d", k), {63'd0, out_valid}, 64'd0);
        end
        issue(vecs[5], 1'b1, lat);
        chk("v5_latency", 64'(lat), 64'd4);
        check_result(5, vecs[5]);
        @(posedge clk); #1;
        chk("v5_ovalid_drop", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
